// File: rtl/lab1_imul_mul_arbiter.sv
// rtl/lab1_imul_mul_arbiter.sv - round-robin sharing of one multiplier among NREQ val/rdy ports
// Responses are steered back through a tag FIFO holding granted requester ids in issue order.
module lab1_imul_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int NTAGS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_val,
    output logic [NREQ-1:0]            req_rdy,
    input  logic [NREQ*64-1:0]         req_msg,
    output logic [NREQ-1:0]            resp_val,
    input  logic [NREQ-1:0]            resp_rdy,
    output logic [31:0]                resp_msg,
    output logic                       mul_istream_val,
    input  logic                       mul_istream_rdy,
    output logic [63:0]                mul_istream_msg,
    input  logic                       mul_ostream_val,
    output logic                       mul_ostream_rdy,
    input  logic [31:0]                mul_ostream_msg,
    output logic [$clog2(NTAGS):0]     inflight,
    output logic                       err
);
    localparam int PW = $clog2(NREQ);
    localparam int AW = (NTAGS > 1) ? $clog2(NTAGS) : 1;
    localparam int CW = $clog2(NTAGS) + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] tags_q [NTAGS];
    logic [PW-1:0] tags_d [NTAGS];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [PW-1:0] grant;
    logic          any_req;
    int            scan_idx;
    logic          full, empty, can_issue, push, pop;
    logic [PW-1:0] head;

    // Scan from the far end so the requester closest to ptr is written last and wins.
    always_comb begin
        grant    = '0;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (req_val[scan_idx]) begin
                grant   = PW'(scan_idx);
                any_req = 1'b1;
            end
        end
    end

    assign full      = (count_q == CW'(NTAGS));
    assign empty     = (count_q == '0);
    assign can_issue = !full && !reset;
    assign head      = tags_q[rd_q];

    assign mul_istream_val = any_req && can_issue;
    assign mul_istream_msg = any_req ? req_msg[64*int'(grant) +: 64] : 64'd0;
    assign req_rdy         = (any_req && can_issue && mul_istream_rdy) ? (NREQ'(1) << grant) : '0;
    assign push            = mul_istream_val && mul_istream_rdy;

    assign resp_val        = (mul_ostream_val && !empty) ? (NREQ'(1) << head) : '0;
    assign resp_msg        = mul_ostream_msg;
    assign mul_ostream_rdy = !empty && resp_rdy[head];
    assign pop             = mul_ostream_val && mul_ostream_rdy;

    assign inflight = count_q;
    assign err      = err_q;

    always_comb begin
        ptr_d   = ptr_q;
        tags_d  = tags_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        err_d   = err_q || (mul_ostream_val && empty);
        if (push) begin
            ptr_d        = (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
            tags_d[wr_q] = grant;
            wr_d         = (wr_q == AW'(NTAGS - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == AW'(NTAGS - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            tags_q  <= tags_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// tb/tb_lab1_imul_mul_arbiter.sv - directed self-checking bench for lab1_imul_mul_arbiter
module tb_lab1_imul_mul_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_val, req_rdy, resp_val, resp_rdy;
    logic [255:0] req_msg;
    logic [31:0]  resp_msg, mul_ostream_msg;
    logic         mul_istream_val, mul_istream_rdy, mul_ostream_val, mul_ostream_rdy;
    logic [63:0]  mul_istream_msg;
    logic [1:0]   inflight;
    logic         err;

    int checks   = 0;
    int failures = 0;

    lab1_imul_mul_arbiter #(.NREQ(4), .NTAGS(2)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .mul_istream_val(mul_istream_val), .mul_istream_rdy(mul_istream_rdy),
        .mul_istream_msg(mul_istream_msg),
        .mul_ostream_val(mul_ostream_val), .mul_ostream_rdy(mul_ostream_rdy),
        .mul_ostream_msg(mul_ostream_msg),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One pop cycle with every requester ready and no new requests.
    task automatic pop_one(input logic [3:0] exp_resp, input string tag);
        req_val         = 4'b0000;
        resp_rdy        = 4'b1111;
        mul_ostream_val = 1'b1;
        settle();
        check(tag, resp_val, exp_resp);
        tick();
        mul_ostream_val = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_val = '0; req_msg = '0; resp_rdy = '0;
        mul_istream_rdy = 1'b1; mul_ostream_val = 1'b0; mul_ostream_msg = '0;
        tick(); tick();
        req_val = 4'b1111;
        settle();
        check("rst_inflight", inflight, 0);
        check("rst_err", err, 0);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_istream_val", mul_istream_val, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_ostream_rdy", mul_ostream_rdy, 0);

        // Single transaction {3,5} -> 15
        req_val = 4'b0000;
        tick();
        reset = 1'b0;
        req_val = 4'b0001;
        req_msg[63:0] = {32'd3, 32'd5};
        settle();
        check("t1_req_rdy", req_rdy, 4'b0001);
        check("t1_istream_val", mul_istream_val, 1);
        check("t1_istream_msg", mul_istream_msg, {32'd3, 32'd5});
        check("t1_inflight0", inflight, 0);
        tick();
        req_val = 4'b0000;
        check("t1_inflight1", inflight, 1);
        mul_ostream_val = 1'b1; mul_ostream_msg = 32'd15; resp_rdy = 4'b1111;
        settle();
        check("t1_resp_val", resp_val, 4'b0001);
        check("t1_resp_msg", resp_msg, 15);
        check("t1_ostream_rdy", mul_ostream_rdy, 1);
        tick();
        mul_ostream_val = 1'b0;
        check("t1_inflight_end", inflight, 0);

        // Fairness from a fresh pointer
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_val = 4'b1111;
            mul_ostream_val = 1'b0;
            settle();
            check("t2_fair_grant", req_rdy, 4'b0001 << (i % 4));
            tick();
            pop_one(4'b0001 << (i % 4), "t2_fair_resp");
        end

        // Wrap/skip: grant 2 moves ptr to 3, then 0101 grants 0 then 2
        req_val = 4'b0100;
        settle();
        check("t3_grant2", req_rdy, 4'b0100);
        tick();
        pop_one(4'b0100, "t3_pop2");
        req_val = 4'b0101;
        settle();
        check("t3_wrap_grant0", req_rdy, 4'b0001);
        tick();
        settle();
        check("t3_skip_grant2", req_rdy, 4'b0100);
        tick();
        check("t3_inflight2", inflight, 2);

        // Full: no issue while full, even on the cycle of a pop
        req_val = 4'b1111;
        mul_istream_rdy = 1'b1;
        settle();
        check("t4_full_rdy", req_rdy, 4'b0000);
        check("t4_full_ival", mul_istream_val, 0);
        mul_ostream_val = 1'b1; resp_rdy = 4'b1111;
        settle();
        check("t4_pop_resp", resp_val, 4'b0001);
        check("t4_pop_same_cycle_rdy", req_rdy, 4'b0000);
        tick();
        mul_ostream_val = 1'b0;
        settle();
        check("t4_resume_grant3", req_rdy, 4'b1000);
        tick();
        pop_one(4'b0100, "t4_drain2");
        pop_one(4'b1000, "t4_drain3");
        check("t4_inflight0", inflight, 0);

        // Order and head-of-line blocking
        req_msg[191:128] = {32'd2, 32'd3};
        req_msg[127:64]  = {32'd5, 32'd7};
        req_val = 4'b0100;
        settle();
        check("t5_msg2", mul_istream_msg, {32'd2, 32'd3});
        tick();
        req_val = 4'b0010;
        settle();
        check("t5_msg1", mul_istream_msg, {32'd5, 32'd7});
        tick();
        req_val = 4'b0000;
        mul_ostream_val = 1'b1; mul_ostream_msg = 32'd6; resp_rdy = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t5_hol_resp", resp_val, 4'b0100);
            check("t5_hol_ordy", mul_ostream_rdy, 0);
            tick();
        end
        resp_rdy = 4'b1111;
        settle();
        check("t5_resp6_val", resp_val, 4'b0100);
        check("t5_resp6_msg", resp_msg, 6);
        tick();
        mul_ostream_msg = 32'd35;
        settle();
        check("t5_resp35_val", resp_val, 4'b0010);
        check("t5_resp35_msg", resp_msg, 35);
        tick();
        mul_ostream_val = 1'b0;
        check("t5_inflight0", inflight, 0);

        // Error on response with empty FIFO, then reset with two in flight
        reset = 1'b1; mul_ostream_val = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("t6_err_ordy", mul_ostream_rdy, 0);
        check("t6_err_resp", resp_val, 0);
        tick();
        mul_ostream_val = 1'b0;
        check("t6_err_set", err, 1);
        tick();
        check("t6_err_sticky", err, 1);
        req_val = 4'b0001;
        tick(); tick();
        req_val = 4'b0000;
        check("t6_inflight2", inflight, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mul_ostream_val = 1'b1;
        settle();
        check("t6_rst_inflight", inflight, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_resp", resp_val, 0);
        check("t6_rst_ordy", mul_ostream_rdy, 0);
        check("t6_rst_req_rdy", req_rdy, 0);
        mul_ostream_val = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
